// File: rtl/seg_pkg.sv
// Shared definitions for the scanned 7-segment counter.
// Provides the button index map, the hex-digit 7-segment code table
// and a decode helper. Segment codes are active-high {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned NUM_BUTTONS = 4;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned SEG_W       = 7;

  localparam int unsigned BTN_INC  = 0;
  localparam int unsigned BTN_DEC  = 1;
  localparam int unsigned BTN_CLR  = 2;
  localparam int unsigned BTN_HOLD = 3;

  // Active-high segment patterns for 0..F ({g,f,e,d,c,b,a}).
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_button  raw asynchronous button level
//   o_pulse   registered single-cycle pulse on an accepted 0->1 level change
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // The accepted level moves only after DEBOUNCE_CYCLES consecutive cycles of
  // the opposite synchronised level; any return to the old level restarts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      o_pulse    <= 1'b0;
    end else begin
      sync1   <= i_button;
      sync2   <= sync1;
      o_pulse <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
        o_pulse    <= sync2;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_scan_counter.sv
// Multi-digit up/down counter with hold snapshot, scanned onto one 7-seg bus.
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_button[3:0]  raw buttons: [0] inc, [1] dec, [2] clear, [3] hold toggle
//   o_digitalTube  segments {g,f,e,d,c,b,a} of the selected digit
//   o_sel          one-hot digit select, bit k = digit k
//   o_led          {ovf, unf, hold, 0, live digit0}
module seg_scan_counter
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter bit          HEX_MODE        = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SCAN_CYCLES     = 50_000,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [3:0]            i_button,
  output logic [SEG_W-1:0]      o_digitalTube,
  output logic [NUM_DIGITS-1:0] o_sel,
  output logic [7:0]            o_led
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = HEX_MODE ? 4'hF : 4'h9;
  localparam logic [SEG_W-1:0]   SEG_ZERO  = SEG_ACTIVE_LOW ? ~SEG_TABLE[0] : SEG_TABLE[0];

  logic [NUM_BUTTONS-1:0] pulse;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] count_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] count_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] snap_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] disp_c;
  logic                               ovf_q;
  logic                               ovf_d;
  logic                               unf_q;
  logic                               unf_d;
  logic                               hold_q;
  logic                               carry;

  logic [PRE_W-1:0] presc_q;
  logic [IDX_W-1:0] idx_q;
  logic [SEG_W-1:0] seg_c;

  logic inc_p;
  logic dec_p;
  logic clr_p;
  logic hold_p;

  // One conditioner per button.
  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    btn_debounce_pulse #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_button (i_button[b]),
      .o_pulse  (pulse[b])
    );
  end

  assign inc_p  = pulse[BTN_INC];
  assign dec_p  = pulse[BTN_DEC];
  assign clr_p  = pulse[BTN_CLR];
  assign hold_p = pulse[BTN_HOLD];

  // Next count: clear wins, inc+dec together cancel, otherwise ripple carry/borrow.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    carry   = 1'b0;
    if (clr_p) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (inc_p && !dec_p) begin
      carry = 1'b1;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (carry) begin
          if (count_q[k] == DIGIT_MAX) begin
            count_d[k] = '0;
          end else begin
            count_d[k] = count_q[k] + DIGIT_W'(1);
            carry      = 1'b0;
          end
        end
      end
      if (carry) ovf_d = 1'b1;
    end else if (dec_p && !inc_p) begin
      carry = 1'b1;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (carry) begin
          if (count_q[k] == '0) begin
            count_d[k] = DIGIT_MAX;
          end else begin
            count_d[k] = count_q[k] - DIGIT_W'(1);
            carry      = 1'b0;
          end
        end
      end
      if (carry) unf_d = 1'b1;
    end
  end

  // Count, flags and hold snapshot; the snapshot captures the pre-update count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      hold_q  <= hold_q ^ hold_p;
      if (hold_p && !hold_q) snap_q <= count_q;
    end
  end

  assign disp_c = hold_q ? snap_q : count_q;
  assign seg_c  = seg_decode(disp_c[idx_q]);

  // Scan prescaler and digit index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRE_W'(SCAN_CYCLES - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Select and segments are registered from the same index so they always agree.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sel         <= NUM_DIGITS'(1);
      o_digitalTube <= SEG_ZERO;
      o_led         <= 8'h00;
    end else begin
      o_sel         <= NUM_DIGITS'(1) << idx_q;
      o_digitalTube <= SEG_ACTIVE_LOW ? ~seg_c : seg_c;
      o_led         <= {ovf_q, unf_q, hold_q, 1'b0, count_q[0]};
    end
  end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Self-checking bench: three instances (4-digit decimal, 4-digit hex,
// 1-digit decimal) share buttons and reset; a reference model predicts
// LED words, pushed to a scoreboard on stimulus and popped after settling.
module tb_seg_scan_counter;

  localparam int unsigned DB = 4;
  localparam int unsigned SC = 3;
  localparam int unsigned HI = 12;  // cycles a button is held / released

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;

  logic [6:0] tube_dec, tube_hex, tube_one;
  logic [3:0] sel_dec, sel_hex;
  logic [0:0] sel_one;
  logic [7:0] led_dec, led_hex, led_one;

  always #5 clk = ~clk;

  seg_scan_counter #(.NUM_DIGITS(4), .HEX_MODE(1'b0), .DEBOUNCE_CYCLES(DB),
                     .SCAN_CYCLES(SC), .SEG_ACTIVE_LOW(1'b1)) u_dec (
    .i_clk(clk), .i_rst(rst), .i_button(btn),
    .o_digitalTube(tube_dec), .o_sel(sel_dec), .o_led(led_dec));

  seg_scan_counter #(.NUM_DIGITS(4), .HEX_MODE(1'b1), .DEBOUNCE_CYCLES(DB),
                     .SCAN_CYCLES(SC), .SEG_ACTIVE_LOW(1'b1)) u_hex (
    .i_clk(clk), .i_rst(rst), .i_button(btn),
    .o_digitalTube(tube_hex), .o_sel(sel_hex), .o_led(led_hex));

  seg_scan_counter #(.NUM_DIGITS(1), .HEX_MODE(1'b0), .DEBOUNCE_CYCLES(DB),
                     .SCAN_CYCLES(SC), .SEG_ACTIVE_LOW(1'b1)) u_one (
    .i_clk(clk), .i_rst(rst), .i_button(btn),
    .o_digitalTube(tube_one), .o_sel(sel_one), .o_led(led_one));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, independent of the RTL structure.
  logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int    ndig [3] = '{4, 4, 1};
  int    base [3] = '{10, 16, 10};
  string name [3] = '{"dec", "hex", "one"};
  int    live [3][4];
  int    snap [3][4];
  bit    m_ovf [3];
  bit    m_unf [3];
  bit    m_hold [3];

  typedef struct {
    int         dut;
    logic [7:0] led;
  } exp_t;
  exp_t sbq [$];

  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) begin
        live[d][k] = 0;
        snap[d][k] = 0;
      end
      m_ovf[d] = 1'b0; m_unf[d] = 1'b0; m_hold[d] = 1'b0;
    end
  endtask

  task automatic m_inc();
    for (int d = 0; d < 3; d++) begin
      bit c = 1'b1;
      for (int k = 0; k < ndig[d]; k++) begin
        if (c) begin
          if (live[d][k] == base[d] - 1) live[d][k] = 0;
          else begin live[d][k]++; c = 1'b0; end
        end
      end
      if (c) m_ovf[d] = 1'b1;
    end
  endtask

  task automatic m_dec();
    for (int d = 0; d < 3; d++) begin
      bit c = 1'b1;
      for (int k = 0; k < ndig[d]; k++) begin
        if (c) begin
          if (live[d][k] == 0) live[d][k] = base[d] - 1;
          else begin live[d][k]--; c = 1'b0; end
        end
      end
      if (c) m_unf[d] = 1'b1;
    end
  endtask

  task automatic m_clr();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) live[d][k] = 0;
      m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
    end
  endtask

  task automatic m_toggle_hold();
    for (int d = 0; d < 3; d++) begin
      if (!m_hold[d]) for (int k = 0; k < 4; k++) snap[d][k] = live[d][k];
      m_hold[d] = !m_hold[d];
    end
  endtask

  function automatic logic [7:0] m_led(input int d);
    return {m_ovf[d], m_unf[d], m_hold[d], 1'b0, 4'(live[d][0])};
  endfunction

  function automatic logic [7:0] get_led(input int d);
    case (d)
      0:       return led_dec;
      1:       return led_hex;
      default: return led_one;
    endcase
  endfunction

  function automatic logic [3:0] get_sel(input int d);
    case (d)
      0:       return sel_dec;
      1:       return sel_hex;
      default: return {3'b000, sel_one};
    endcase
  endfunction

  function automatic logic [6:0] get_tube(input int d);
    case (d)
      0:       return tube_dec;
      1:       return tube_hex;
      default: return tube_one;
    endcase
  endfunction

  task automatic push_expect();
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      e.dut = d;
      e.led = m_led(d);
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      chk($sformatf("%s_led_%s", tag, name[e.dut]), 32'(get_led(e.dut)), 32'(e.led));
    end
  endtask

  // Predict the outcome of a button combination, then press and release it.
  task automatic do_press(input logic [3:0] mask, input string tag);
    if (mask[2])                 m_clr();
    else if (mask[0] && mask[1]) ;
    else if (mask[0])            m_inc();
    else if (mask[1])            m_dec();
    if (mask[3])                 m_toggle_hold();
    push_expect();
    @(posedge clk); #1 btn = mask;
    repeat (HI) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (HI) @(posedge clk);
    drain(tag);
  endtask

  // Watch two full frames and compare every segment word with the model display.
  task automatic scan_check(input int d, input string tag);
    for (int c = 0; c < 2 * 4 * int'(SC); c++) begin
      @(negedge clk);
      for (int k = 0; k < ndig[d]; k++) begin
        if (get_sel(d) == 4'(1 << k)) begin
          int         v   = m_hold[d] ? snap[d][k] : live[d][k];
          logic [6:0] exp = ~seg_hi[v];
          chk($sformatf("%s_tube_%s_d%0d", tag, name[d], k), 32'(get_tube(d)), 32'(exp));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 4'b0000;
    m_reset();

    // Reset state and scan order.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_led_%s", name[d]), 32'(get_led(d)), 32'h00);
      chk($sformatf("rst_sel_%s", name[d]), 32'(get_sel(d)), 32'h1);
      chk($sformatf("rst_tube_%s", name[d]), 32'(get_tube(d)), 32'h40);
    end
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      chk($sformatf("scan_sel_%0d", j), 32'(sel_dec), 32'(1 << ((j / SC) % 4)));
    end

    // Bounce then a long stable press gives exactly one increment.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b1; repeat (2) @(posedge clk); #1;
      btn[0] = 1'b0; repeat (2) @(posedge clk); #1;
    end
    m_inc();
    push_expect();
    btn[0] = 1'b1;
    repeat (10) @(posedge clk);
    drain("bounce");
    push_expect();
    repeat (100) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (HI) @(posedge clk);
    drain("held");

    // Hold freezes the display while the live count moves.
    do_press(4'b0001, "inc2");
    do_press(4'b0001, "inc3");
    do_press(4'b1000, "hold_on");
    do_press(4'b0001, "inc4");
    do_press(4'b0001, "inc5");
    scan_check(0, "frozen");
    do_press(4'b1000, "hold_off");
    scan_check(0, "live");

    // Same-cycle combinations.
    do_press(4'b0011, "inc_dec");
    do_press(4'b0101, "clr_inc");

    // Carry across digits; single-digit decimal overflows on the tenth press.
    for (int i = 0; i < 10; i++) do_press(4'b0001, $sformatf("carry%0d", i));
    scan_check(1, "hex_a");
    do_press(4'b0100, "clr1");

    // Underflow from zero, then overflow back to zero.
    do_press(4'b0010, "unf");
    scan_check(1, "hex_f");
    scan_check(0, "dec_9");
    do_press(4'b0001, "ovf");
    do_press(4'b0100, "clr2");

    // Reset in the middle of a debounce with the button still held.
    @(posedge clk); #1 btn = 4'b0001;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    m_inc();
    push_expect();
    repeat (HI) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (HI) @(posedge clk);
    drain("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_counter.md
# seg_scan_counter

Parametrised successor to the four-button / single-tube counter top. Four debounced buttons drive a NUM_DIGITS-digit up/down counter in decimal or hex, with clear and display-hold. The block time-multiplexes all digits onto one shared 7-segment bus with a one-hot digit select, and mirrors status on the LED bank. It sits directly under the board top, between the raw button pins and the tube/LED pins.

## Interface
- NUM_DIGITS, 4: digit count (1..8); sets width of o_sel.
- HEX_MODE, 0: 0 = each digit is base 10 (0..9); 1 = base 16 (0..F).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a button level is accepted (≥2).
- SCAN_CYCLES, 50_000: cycles each digit stays selected (≥1).
- SEG_ACTIVE_LOW, 1: 1 = segment bit 0 lights the segment.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_button  in  4  raw asynchronous active-high buttons: [0] inc, [1] dec, [2] clear, [3] hold toggle.
- o_digitalTube  out  7  segments {g,f,e,d,c,b,a} for the currently selected digit, polarity per SEG_ACTIVE_LOW.
- o_sel  out  NUM_DIGITS  one-hot digit select, active-high; bit k = digit k (digit 0 = least significant).
- o_led  out  8  {ovf, unf, hold, 1'b0, digit0[3:0]}.

## Operation
- Each button passes through a 2-FF synchroniser, then a stability counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronised level. A debounced 0→1 edge yields a single-cycle press pulse; release produces nothing.
- Same-cycle priority: clear > (inc and dec together → no change) > inc > dec. Hold is independent of the other buttons and is evaluated in the same cycle.
- Inc: ripple-carry across digits; a digit at its max (9 or F) goes to 0 and carries. If all digits are at max, the result is all zero and the sticky ovf flag is set.
- Dec: a borrow takes a digit at 0 to its max. All-zero minus one gives all digits at max and sets the sticky unf flag.
- Clear: all digits = 0, ovf = unf = 0. Hold is unaffected.
- Hold toggle: on entering hold, the current count is copied into a display snapshot. While hold = 1, the scan shows the snapshot while the live count keeps changing. Leaving hold returns to the live count. ovf, unf and o_led digit0 always reflect the live count.
- Scan: a prescaler counts 0..SCAN_CYCLES-1. At terminal count the digit index advances, wrapping NUM_DIGITS-1→0. o_sel = 1<<index. o_digitalTube = decode(selected digit) from the shared package table for 0..F. HEX_MODE=0 never produces digit values above 9.

## Timing
- Reset values: digits all 0, snapshot 0, hold 0, ovf 0, unf 0, scan index 0, prescaler 0, debounced levels 0.
- Outputs at reset: o_sel = 1, o_digitalTube = code for '0' (7'b1000000 when active-low), o_led = 8'h00.
- Button latency: i_button rises before edge t and stays stable → press pulse high during cycle t+2+DEBOUNCE_CYCLES → count register updated at the following edge.
- o_led, o_sel and o_digitalTube are all registered. o_led follows the count register one cycle later. o_sel and o_digitalTube change on the same edge, so no mismatched frame ever appears.
- Each digit is selected for exactly SCAN_CYCLES cycles. A full frame is NUM_DIGITS × SCAN_CYCLES cycles.
- Bounce shorter than DEBOUNCE_CYCLES yields no pulse. A held button yields exactly one pulse.
- Reset asserted mid-debounce or mid-scan aborts everything and reaches reset state on the next edge. A button still held high after reset release yields one pulse once it is stable for DEBOUNCE_CYCLES.

## Structure
- Package seg_pkg holds:
  - the 16-entry 7-segment code table and a decode function;
  - button index constants (BTN_INC = 0, BTN_DEC = 1, BTN_CLR = 2, BTN_HOLD = 3).
- Sub-module btn_debounce_pulse (parameter DEBOUNCE_CYCLES; ports i_clk, i_rst, i_button, o_pulse) contains the synchroniser, stability counter and edge detect. It is instantiated 4× via generate.
- Counter, hold snapshot, scan and output registers live in the top of this block.

## Test plan
All scenarios use NUM_DIGITS=4, DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, SEG_ACTIVE_LOW=1 unless stated.
- Reset: i_rst high 2 cycles → o_sel=4'b0001, o_digitalTube=7'b1000000, o_led=8'h00. Then o_sel steps 0001→0010→0100→1000→0001, with every 3 cycles per digit.
- Debounce: inc toggles every 2 cycles for 20 cycles, then holds high for 10 → exactly one increment, o_led=8'h01. Holding 100 more cycles gives no further change.
- Decimal carry/overflow (HEX_MODE=0): 9999 loaded by 9999 inc presses or by forcing, then inc → all digits 0, o_led=8'h80. Then clear → o_led=8'h00.
- Hex underflow (HEX_MODE=1): from 0000, one dec → FFFF, o_led=8'h4F. Digit 3 scan shows 7'b0001110 ('F').
- Simultaneous buttons: inc and dec pulse in the same cycle at count 0005 → no change. Clear with inc in the same cycle → 0000.
- Hold: count 0003, then hold, then 2 inc → scanned digits still show 0003, o_led=8'h25. Hold again → scanned digit 0 shows '5'.
